// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable 50%-duty clock dividers behind an Avalon-MM register slave.
// Latency: reads combinational, writes act at the edge, clk_out/tick registered; no backpressure (zero wait states).
module clk_div_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic              wr;
    logic              ctrl_wr;
    logic              restart;
    logic [NUM_CH-1:0] ctrl;
    logic [NUM_CH-1:0] ctrl_nxt;
    logic [NUM_CH-1:0] status;
    logic [CNT_W-1:0]  div_q [NUM_CH];

    assign wr       = chipselect && !write_n;
    assign ctrl_wr  = wr && (address == 4'd0);
    assign restart  = ctrl_wr && writedata[31];
    assign ctrl_nxt = ctrl_wr ? writedata[NUM_CH-1:0] : ctrl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= '0;
            end
        end else begin
            ctrl <= ctrl_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr && (address == 4'(i + 2))) begin
                    div_q[i] <= writedata[CNT_W-1:0];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] adiv;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] reload;
        logic             lvl;
        logic             lvl_nxt;
        logic             rise;
        logic             load;

        // A zero divisor parks the counter at 0 so every cycle is a reload that can pick up a new DIV.
        assign reload  = (div_q[g] == '0) ? '0 : div_q[g] - ONE;
        assign load    = (ctrl_nxt[g] && !ctrl[g]) || restart;
        assign lvl_nxt = (adiv != '0) && (div_q[g] != '0) && !lvl;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                adiv <= '0;
                cnt  <= '0;
                lvl  <= 1'b0;
                rise <= 1'b0;
            end else if (!ctrl_nxt[g]) begin
                adiv <= div_q[g];
                cnt  <= '0;
                lvl  <= 1'b0;
                rise <= 1'b0;
            end else if (load) begin
                adiv <= div_q[g];
                cnt  <= reload;
                lvl  <= 1'b0;
                rise <= 1'b0;
            end else if (cnt == '0) begin
                adiv <= div_q[g];
                cnt  <= reload;
                lvl  <= lvl_nxt;
                rise <= lvl_nxt;
            end else begin
                cnt  <= cnt - ONE;
                rise <= 1'b0;
            end
        end

        assign clk_out[g] = lvl;
        assign tick[g]    = rise;
        assign status[g]  = ctrl[g] && (adiv != '0);
    end

    always_comb begin
        readdata = '0;
        if (address == 4'd0) begin
            readdata[NUM_CH-1:0] = ctrl;
        end else if (address == 4'd1) begin
            readdata[NUM_CH-1:0] = status;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (address == 4'(i + 2)) begin
                    readdata[CNT_W-1:0] = div_q[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: register vectors, directed divider sequences, random traffic vs a schedule model.
`timescale 1ns/1ps
module tb_clk_div_bank;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [3:0]        address = '0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    // Reference: each enabled channel schedules its next half-period boundary as an absolute cycle number.
    logic [NUM_CH-1:0] m_ctrl;
    logic [NUM_CH-1:0] m_lvl;
    logic [NUM_CH-1:0] m_tick;
    int m_div  [NUM_CH];
    int m_adiv [NUM_CH];
    int m_next [NUM_CH];
    int cyc;

    function void model_reset();
        m_ctrl = '0;
        m_lvl  = '0;
        m_tick = '0;
        cyc    = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i] = 0; m_adiv[i] = 0; m_next[i] = 0;
        end
    endfunction

    function void model_step(input logic cs, input logic wn, input logic [3:0] a, input logic [31:0] d);
        logic wrv, rs, lv;
        logic [NUM_CH-1:0] en_new;
        wrv = cs && !wn;
        en_new = m_ctrl;
        rs = 1'b0;
        cyc++;
        if (wrv && a == 4'd0) begin
            en_new = d[NUM_CH-1:0];
            rs = d[31];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            lv = m_lvl[i];
            if (!en_new[i]) begin
                m_lvl[i] = 1'b0;
                m_adiv[i] = m_div[i];
            end else if (!m_ctrl[i] || rs) begin
                m_lvl[i] = 1'b0;
                m_adiv[i] = m_div[i];
                m_next[i] = cyc + ((m_div[i] > 0) ? m_div[i] : 1);
            end else if (cyc == m_next[i]) begin
                m_lvl[i] = (m_adiv[i] != 0 && m_div[i] != 0) ? !lv : 1'b0;
                m_adiv[i] = m_div[i];
                m_next[i] = cyc + ((m_div[i] > 0) ? m_div[i] : 1);
            end
            m_tick[i] = m_lvl[i] && !lv;
        end
        m_ctrl = en_new;
        if (wrv && int'(a) >= 2 && int'(a) < 2 + NUM_CH)
            m_div[int'(a) - 2] = int'(d[CNT_W-1:0]);
    endfunction

    function logic [31:0] model_rd(input logic [3:0] a);
        logic [31:0] r;
        r = '0;
        if (a == 4'd0) r[NUM_CH-1:0] = m_ctrl;
        else if (a == 4'd1) begin
            for (int i = 0; i < NUM_CH; i++) r[i] = m_ctrl[i] && (m_adiv[i] != 0);
        end else if (int'(a) < 2 + NUM_CH) r = 32'(m_div[int'(a) - 2]);
        return r;
    endfunction

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic step(input logic cs, input logic wn, input logic [3:0] a, input logic [31:0] d);
        chipselect = cs; write_n = wn; address = a; writedata = d;
        @(posedge clk);
        model_step(cs, wn, a, d);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
        @(negedge clk);
        chk("clk_out", 32'(clk_out), 32'(m_lvl));
        chk("tick", 32'(tick), 32'(m_tick));
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, a, d);
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 4'd0, 32'd0);
    endtask

    task automatic chk_rd(input logic [3:0] a);
        address = a;
        #1;
        chk($sformatf("rd[%0d]", a), readdata, model_rd(a));
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs[10];

    logic [31:0] exp_lvl [9];
    logic [3:0]  ra;
    logic [31:0] rdat;
    logic        rcs, rwn;
    int          r;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'd2,  32'hFFFF_FFFF, 32'h0000_00FF};
        vecs[1] = '{4'd15, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[2] = '{4'd3,  32'h0000_0123, 32'h0000_0023};
        vecs[3] = '{4'd5,  32'hABCD_EF07, 32'h0000_0007};
        vecs[4] = '{4'd1,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5] = '{4'd10, 32'h1234_5678, 32'h0000_0000};
        vecs[6] = '{4'd0,  32'h0000_00F0, 32'h0000_0000};
        vecs[7] = '{4'd0,  32'h0000_0005, 32'h0000_0005};
        vecs[8] = '{4'd4,  32'h0000_005A, 32'h0000_005A};
        vecs[9] = '{4'd0,  32'h7FFF_FFF3, 32'h0000_0003};
        exp_lvl = '{0, 0, 0, 0, 1, 1, 0, 0, 1};

        // Reset state
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset clk_out", 32'(clk_out), 32'd0);
        chk("reset tick", 32'(tick), 32'd0);
        for (int a = 0; a < 16; a++) begin
            address = 4'(a); #1;
            chk($sformatf("reset rd[%0d]", a), readdata, 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            address = vecs[i].addr; #1;
            chk($sformatf("vec%0d", i), readdata, vecs[i].exp_rd);
        end

        // DIV=3 enable: rise at T+3, fall T+6, rise T+9
        wr(4'd0, 32'd0);
        wr(4'd2, 32'd3);
        wr(4'd0, 32'd1);
        chk("r031 k0", 32'(clk_out[0]), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            idle();
            chk($sformatf("r031 clk k%0d", k), 32'(clk_out[0]), 32'((k >= 3 && k < 6) || k >= 9));
            chk($sformatf("r031 tick k%0d", k), 32'(tick[0]), 32'(k == 3 || k == 9));
        end

        // DIV change mid half-period applies at the following reload
        wr(4'd0, 32'd0);
        wr(4'd2, 32'd4);
        wr(4'd0, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            if (k == 2) begin
                wr(4'd2, 32'd2);
                address = 4'd2; #1;
                chk("r032 div rd", readdata, 32'd2);
            end else idle();
            chk($sformatf("r032 clk k%0d", k), 32'(clk_out[0]), exp_lvl[k]);
        end

        // Shared RESTART realigns two running channels
        wr(4'd0, 32'd0);
        wr(4'd3, 32'd5);
        wr(4'd4, 32'd7);
        wr(4'd0, 32'd2);
        repeat (3) idle();
        wr(4'd0, 32'd6);
        repeat (4) idle();
        wr(4'd0, 32'h8000_0006);
        chk("r033 low", 32'(clk_out[2:1]), 32'd0);
        address = 4'd0; #1;
        chk("r033 ctrl rd", readdata, 32'h6);
        for (int k = 1; k <= 8; k++) begin
            idle();
            chk($sformatf("r033 tick1 k%0d", k), 32'(tick[1]), 32'(k == 5));
            chk($sformatf("r033 tick2 k%0d", k), 32'(tick[2]), 32'(k == 7));
            chk($sformatf("r033 clk1 k%0d", k), 32'(clk_out[1]), 32'(k >= 5));
            chk($sformatf("r033 clk2 k%0d", k), 32'(clk_out[2]), 32'(k >= 7));
        end

        // Zero divisor parks the channel; DIV=1 toggles every cycle
        wr(4'd0, 32'd0);
        wr(4'd2, 32'd0);
        wr(4'd0, 32'd1);
        for (int k = 1; k <= 10; k++) begin
            idle();
            chk("r034 parked clk", 32'(clk_out[0]), 32'd0);
            chk("r034 parked tick", 32'(tick[0]), 32'd0);
        end
        address = 4'd1; #1;
        chk("r034 status0", readdata, 32'd0);
        wr(4'd2, 32'd1);
        wr(4'd0, 32'd1);
        for (int k = 1; k <= 6; k++) begin
            idle();
            chk($sformatf("r034 div1 k%0d", k), 32'(clk_out[0]), 32'(k % 2 == 1));
        end
        address = 4'd1; #1;
        chk("r034 status1", readdata, 32'd1);

        // Disable while high, then asynchronous reset mid-period
        wr(4'd0, 32'd0);
        wr(4'd2, 32'd3);
        wr(4'd0, 32'd1);
        for (int w = 0; w < 20 && !m_lvl[0]; w++) idle();
        chk("r035 high", 32'(clk_out[0]), 32'd1);
        wr(4'd0, 32'd0);
        chk("r035 disabled clk", 32'(clk_out[0]), 32'd0);
        chk("r035 disabled tick", 32'(tick[0]), 32'd0);
        wr(4'd3, 32'd2);
        wr(4'd4, 32'd3);
        wr(4'd0, 32'h7);
        repeat (4) idle();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("r035 async clk_out", 32'(clk_out), 32'd0);
        chk("r035 async tick", 32'(tick), 32'd0);
        for (int a = 0; a < 16; a++) chk_rd(4'(a));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) idle();
        chk_rd(4'd0);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 15);
            rcs = 1'b0; rwn = 1'b1;
            ra = 4'($urandom_range(0, 15));
            rdat = $urandom;
            if (r < 3) begin
                rcs = 1'b1; rwn = 1'b0; ra = 4'd0;
                rdat = rdat & 32'h7FFF_FFFF;
                if ($urandom_range(0, 4) == 0) rdat[31] = 1'b1;
            end else if (r < 7) begin
                rcs = 1'b1; rwn = 1'b0;
                ra = 4'(2 + $urandom_range(0, NUM_CH - 1));
                if ($urandom_range(0, 7) != 0) rdat = 32'($urandom_range(0, 6));
            end else if (r == 7) begin
                rcs = 1'b1; rwn = 1'b1;
            end else if (r == 8) begin
                rcs = 1'b0; rwn = 1'b0;
            end
            step(rcs, rwn, ra, rdat);
            chk_rd(4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
